// File: rtl/game_pkg.sv
// Shared constants and types for the draw-stage sprite renderers (player and enemies).
// Covers screen geometry, colour format, facing encoding and the sprite ROM address layout.
package game_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int COLOUR_W = 9;
    localparam logic [COLOUR_W-1:0] TRANSPARENT = 9'h1FF;

    localparam int X_W = 9;
    localparam int Y_W = 8;

    localparam int DIR_W        = 2;
    localparam int SPRITE_ROW_W = 4;
    localparam int SPRITE_COL_W = 4;
    localparam int SPRITE_ADDR_W = DIR_W + 1 + SPRITE_ROW_W + SPRITE_COL_W;

    typedef enum logic [DIR_W-1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Sprite ROM address: one 16x16 image per (facing, frame) pair.
    typedef struct packed {
        dir_t                    dir;
        logic                    frame;
        logic [SPRITE_ROW_W-1:0] row;
        logic [SPRITE_COL_W-1:0] col;
    } sprite_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_RELEASE
    } draw_state_t;

endpackage

// File: rtl/sprite_pixel_counter.sv
// Row-major sprite pixel counter (col fastest) with clear, enable and last-pixel flag.
module sprite_pixel_counter #(
    parameter int COL_W = 4,
    parameter int ROW_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    logic [ROW_W+COL_W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign {row, col} = count_reg;
    assign last       = &count_reg;

endmodule

// File: rtl/link_sprite_drawer.sv
// Renders the 16x16 player sprite into the VGA framebuffer while draw_link is held,
// skipping transparent and off-screen pixels, then pulses draw_link_done once.
import game_pkg::*;

module link_sprite_drawer #(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     draw_link,
    input  logic [X_W-1:0]           link_x,
    input  logic [Y_W-1:0]           link_y,
    input  logic [1:0]               link_dir,
    input  logic                     link_frame,
    output logic [SPRITE_ADDR_W-1:0] rom_addr,
    input  logic [COLOUR_W-1:0]      rom_data,
    output logic [X_W-1:0]           vga_x,
    output logic [Y_W-1:0]           vga_y,
    output logic [COLOUR_W-1:0]      vga_colour,
    output logic                     vga_plot,
    output logic                     draw_link_done
);

    localparam int COL_W = $clog2(SPRITE_W);
    localparam int ROW_W = $clog2(SPRITE_H);

    draw_state_t state_reg, state_next;

    logic [X_W-1:0] lx_reg;
    logic [Y_W-1:0] ly_reg;
    dir_t           dir_reg;
    logic           frame_reg;

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             last;
    logic             start;
    logic             advance;
    logic             active_next;

    // Stage 1 sits alongside rom_data; coordinates carry one extra bit so off-screen sums never wrap.
    logic           s1_valid_reg;
    logic [X_W:0]   s1_x_reg;
    logic [Y_W:0]   s1_y_reg;
    sprite_addr_t   addr;

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        advance    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (draw_link) begin
                    start      = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!draw_link) begin
                    state_next = ST_IDLE;
                end else if (last) begin
                    state_next = ST_DRAIN;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Stage 1 empties one cycle into DRAIN; the output stage emits the last pixel as we leave.
                if (!draw_link) begin
                    state_next = ST_IDLE;
                end else if (!s1_valid_reg) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:    state_next = ST_RELEASE;
            ST_RELEASE: begin
                if (!draw_link) begin
                    state_next = ST_IDLE;
                end
            end
            default:    state_next = ST_IDLE;
        endcase
        active_next = (state_next == ST_RUN) || (state_next == ST_DRAIN);
    end

    assign draw_link_done = (state_reg == ST_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lx_reg    <= '0;
            ly_reg    <= '0;
            dir_reg   <= DIR_UP;
            frame_reg <= 1'b0;
        end else if (start) begin
            lx_reg    <= link_x;
            ly_reg    <= link_y;
            dir_reg   <= dir_t'(link_dir);
            frame_reg <= link_frame;
        end
    end

    sprite_pixel_counter #(
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) pixel_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (start),
        .enable (advance),
        .row    (row),
        .col    (col),
        .last   (last)
    );

    // Address is built purely from flops, so it behaves as a registered output.
    always_comb begin
        addr.dir   = dir_reg;
        addr.frame = frame_reg;
        addr.row   = row;
        addr.col   = col;
    end

    assign rom_addr = addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_x_reg     <= '0;
            s1_y_reg     <= '0;
            vga_x        <= '0;
            vga_y        <= '0;
            vga_colour   <= '0;
            vga_plot     <= 1'b0;
        end else begin
            s1_valid_reg <= (state_reg == ST_RUN) && draw_link;
            s1_x_reg     <= {1'b0, lx_reg} + (X_W+1)'(col);
            s1_y_reg     <= {1'b0, ly_reg} + (Y_W+1)'(row);
            vga_x        <= s1_x_reg[X_W-1:0];
            vga_y        <= s1_y_reg[Y_W-1:0];
            vga_colour   <= rom_data;
            // Gating on the next state drops in-flight pixels on abort.
            vga_plot     <= s1_valid_reg
                            && (rom_data != TRANSPARENT)
                            && (s1_x_reg < (X_W+1)'(SCREEN_W))
                            && (s1_y_reg < (Y_W+1)'(SCREEN_H))
                            && active_next;
        end
    end

endmodule

// File: doc/link_sprite_drawer.md
Name: link_sprite_drawer

Overview:
Draw-stage datapath slice that renders the player sprite into the VGA adapter framebuffer. It runs when the top-level control FSM holds draw_link high. It walks a 16x16 sprite stored in an external ROM with one-cycle read latency. It skips transparent and off-screen pixels and returns a one-cycle draw_link_done so control can advance to enemy drawing.

Parameters:
SPRITE_W, 16, sprite width in pixels (power of 2)
SPRITE_H, 16, sprite height in pixels (power of 2)
SCREEN_W, 320, visible width; x >= SCREEN_W is clipped
SCREEN_H, 240, visible height; y >= SCREEN_H is clipped
COLOUR_W, 9, VGA colour width (3 bits per channel)
TRANSPARENT, 9'h1FF, ROM colour value that is never plotted

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
draw_link  in  1  level enable from control; high for the whole draw-link state
link_x  in  9  sprite top-left x; latched at start
link_y  in  8  sprite top-left y; latched at start
link_dir  in  2  facing: 0 up, 1 down, 2 left, 3 right; latched at start
link_frame  in  1  animation frame; latched at start
rom_addr  out  11  {dir, frame, row[3:0], col[3:0]}; registered
rom_data  in  9  sprite colour; valid the cycle after rom_addr
vga_x  out  9  pixel x; registered
vga_y  out  8  pixel y; registered
vga_colour  out  9  pixel colour; registered
vga_plot  out  1  write strobe for the VGA adapter; registered
draw_link_done  out  1  one-cycle completion pulse to control

Behaviour:
- Reset: state IDLE. All outputs are 0, the counters are 0, and the pipeline valid bits are 0. Reset mid-draw aborts immediately and produces no done pulse.
- States: IDLE, RUN, DRAIN, DONE, RELEASE.
- IDLE: when draw_link = 1 at an edge, latch link_x, link_y, link_dir and link_frame. On the same edge, set the pixel counter to 0, drive rom_addr for pixel 0 and go to RUN.
- Cycle numbering: C1 is the cycle after the sampling edge.
- RUN: in Ck (k = 1..256), rom_addr is the address for pixel k-1. Pixels are in row-major order, col fastest. The counter increments each cycle. After pixel 255 is issued, go to DRAIN.
- Pipeline:
  - Stage-1 registers carry valid, x = lx + col and y = ly + row, aligned with rom_data.
  - The output registers load vga_x, vga_y and vga_colour every cycle.
  - vga_plot = s1_valid AND rom_data != TRANSPARENT AND x < SCREEN_W AND y < SCREEN_H.
  - Pixel i appears on the vga_* outputs in cycle C(i+3).
- Width rule: sum x in 10 bits and y in 9 bits before the clip compare. Clipped pixels never wrap onto the screen.
- DRAIN: lasts 2 cycles (C257, C258) so the last pixel is emitted. Then go to DONE.
- DONE (C259): draw_link_done = 1 for exactly one cycle and vga_plot = 0. Then go to RELEASE.
- RELEASE: wait until draw_link = 0, then go to IDLE. This prevents a retrigger while control is still in the draw-link state.
- Abort: if draw_link = 0 in RUN or DRAIN, go to IDLE at that edge and clear the pipeline valids. In-flight pixels are dropped and no done pulse is issued.
- In IDLE and RELEASE, vga_plot = 0 and draw_link_done = 0.
- Inputs link_* changing after the latch edge have no effect on the current draw.

Decomposition:
- Shared package game_pkg:
  - SCREEN_W, SCREEN_H, COLOUR_W, TRANSPARENT
  - the direction encoding (DIR_UP/DOWN/LEFT/RIGHT)
  - the X/Y coordinate widths
  - the sprite address field layout
- The enemy drawer reuses this package.
- One natural sub-module, sprite_pixel_counter: a row/col counter with clear, enable and last-pixel flag. The enemy drawer reuses it.
- The sprite ROM stays outside this block.

Test Plan:
- Nominal draw: link_x = 100, link_y = 50, dir = 1, frame = 0, model ROM with no transparent pixels.
  - draw_link held high gives 256 plots, the first at (100,50) in C3 and the last at (115,65) in C258.
  - rom_addr for pixel 0 = 11'h200.
  - draw_link_done is high only in C259.
- Transparency: ROM returns 9'h1FF for all even col.
  - Exactly 128 plots, all with odd vga_x - 100.
  - Done still in C259.
- Clipping: link_x = 312, link_y = 232.
  - Only pixels with x <= 319 and y <= 239 plot, 8x8 = 64 plots, no wrapped coordinates.
  - Done in C259.
- Abort: drop draw_link in C100.
  - No plots after C102 and no done pulse.
  - Block returns to IDLE.
  - Re-raising draw_link restarts at pixel 0.
- Reset mid-draw: assert reset in C50.
  - Next cycle all outputs are 0 and the state is IDLE.
  - After release with draw_link high, a full 256-pixel draw follows.
- Held enable: keep draw_link high 10 cycles after done.
  - No second draw and no second done.
  - Lowering then raising draw_link starts a new draw.
